logic_unit_pipe: RTL and testbench

//  Parametrised, registered bitwise logic unit that generalises the fixed 16-bit inverter.

---
 rtl/logic_unit_pipe.sv | 135 +++++++++++++
 tb/tb_logic_unit_pipe.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/logic_unit_pipe.sv
// -----------------------------------------------------------------------------
// logic_unit_pipe
//   Registered bitwise logic unit with valid/ready handshakes on both sides and
//   a small result FIFO that absorbs consumer back-pressure. The result and its
//   zero flag are computed combinationally from the operands. They are written
//   into the FIFO on accept, so no combinational path runs from in_* to out_*.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand transaction valid
//   in_ready   unit can accept (FIFO not full, registered count only)
//   in_op      opcode: 000 ~A, 001 ~(A&B), 010 A&B, 011 A|B, 100 ~(A|B),
//              101 A^B, 110 ~(A^B), 111 -A (two's complement, truncated)
//   in_a/in_b  operands (in_b unused for NOT/NEG)
//   out_valid  FIFO head holds a result
//   out_ready  consumer takes the head result
//   out_data   head result
//   out_zero   head result == 0
//   op_count   accepted transactions, modulo 2^CNT_W
// -----------------------------------------------------------------------------
module logic_unit_pipe #(
  parameter int WIDTH      = 16,
  parameter int FIFO_DEPTH = 2,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero,
  output logic [CNT_W-1:0] op_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CW    = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic [WIDTH-1:0]      mem_data_reg [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] mem_zero_reg;
  logic [PTR_W-1:0]      wr_ptr_reg;
  logic [PTR_W-1:0]      rd_ptr_reg;
  logic [CW-1:0]         count_reg;
  logic [CNT_W-1:0]      op_count_reg;

  logic [WIDTH-1:0]      result_next;
  logic                  zero_next;
  logic                  push;
  logic                  pop;
  logic [FIFO_DEPTH-1:0] entry_we;

  // Operation select
  always_comb begin
    result_next = '0;
    case (in_op)
      3'b000:  result_next = ~in_a;
      3'b001:  result_next = ~(in_a & in_b);
      3'b010:  result_next = in_a & in_b;
      3'b011:  result_next = in_a | in_b;
      3'b100:  result_next = ~(in_a | in_b);
      3'b101:  result_next = in_a ^ in_b;
      3'b110:  result_next = ~(in_a ^ in_b);
      3'b111:  result_next = ~in_a + WIDTH'(1);  // carry out dropped
      default: result_next = '0;
    endcase
  end

  assign zero_next = (result_next == '0);

  // in_ready depends only on the registered count, so a pop in the same cycle
  // as a full FIFO does not open the input until the following cycle.
  assign in_ready  = (count_reg < DEPTH_C);
  assign out_valid = (count_reg != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Per-entry write enables decoded from the write pointer
  generate
    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_we
      assign entry_we[gi] = push && (wr_ptr_reg == PTR_W'(gi));
    end
  endgenerate

  // Storage is cleared on reset so out_data/out_zero read 0 while empty after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_data_reg[i] <= '0;
      end
      mem_zero_reg <= '0;
    end else begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        if (entry_we[i]) begin
          mem_data_reg[i] <= result_next;
          mem_zero_reg[i] <= zero_next;
        end
      end
    end
  end

  // Pointers, occupancy and transaction counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      op_count_reg <= '0;
    end else begin
      // Power-of-two depth: natural pointer overflow gives the modulo wrap.
      if (push) begin
        wr_ptr_reg   <= wr_ptr_reg + PTR_W'(1);
        op_count_reg <= op_count_reg + CNT_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign out_data = mem_data_reg[rd_ptr_reg];
  assign out_zero = mem_zero_reg[rd_ptr_reg];
  assign op_count = op_count_reg;

endmodule

// File: tb/tb_logic_unit_pipe.sv
module tb_logic_unit_pipe;

  localparam int WIDTH = 16;
  localparam int DEPTH = 2;
  localparam int CNT_W = 8;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_zero;
  logic [CNT_W-1:0] op_count;

  logic_unit_pipe #(.WIDTH(WIDTH), .FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_zero(out_zero), .op_count(op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [15:0] d;
    logic        z;
  } ent_t;

  ent_t q[$];      // expected FIFO contents, head at index 0
  int   m_count;   // expected op_count

  typedef struct {
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp_d;
    logic        exp_z;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result from the opcode table, using plain integer arithmetic.
  function automatic ent_t model_result(input logic [2:0] op, input int a, input int b);
    int r;
    ent_t e;
    case (op)
      3'd0: r = 65535 - a;
      3'd1: r = 65535 - (a & b);
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = 65535 - (a | b);
      3'd5: r = a ^ b;
      3'd6: r = 65535 - (a ^ b);
      default: r = (65536 - a) % 65536;
    endcase
    e.d = 16'(r);
    e.z = (r == 0);
    return e;
  endfunction

  // One clock cycle: drive inputs, check outputs against the model, clock, update model.
  task automatic cycle(input logic v, input logic [2:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic ordy);
    logic acc;
    logic pp;
    ent_t e;
    in_valid  = v;
    in_op     = op;
    in_a      = a;
    in_b      = b;
    out_ready = ordy;
    #1;
    chk("in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      chk("out_data", 32'(out_data), 32'(q[0].d));
      chk("out_zero", 32'(out_zero), 32'(q[0].z));
    end
    chk("op_count", 32'(op_count), 32'(m_count));
    acc = v && (q.size() < DEPTH);
    pp  = (q.size() != 0) && ordy;
    e   = model_result(op, int'(a), int'(b));
    @(posedge clk);
    #1;
    if (pp) void'(q.pop_front());
    if (acc) begin
      q.push_back(e);
      m_count = (m_count + 1) % 256;
    end
  endtask

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{3'd1, 16'hF0F0, 16'hFF00, 16'h0FFF, 1'b0};
    vecs[1]  = '{3'd2, 16'hF0F0, 16'hFF00, 16'hF000, 1'b0};
    vecs[2]  = '{3'd3, 16'hF0F0, 16'hFF00, 16'hFFF0, 1'b0};
    vecs[3]  = '{3'd4, 16'hF0F0, 16'hFF00, 16'h000F, 1'b0};
    vecs[4]  = '{3'd5, 16'hAAAA, 16'h5555, 16'hFFFF, 1'b0};
    vecs[5]  = '{3'd6, 16'hAAAA, 16'h5555, 16'h0000, 1'b1};
    vecs[6]  = '{3'd0, 16'h1234, 16'hFFFF, 16'hEDCB, 1'b0};
    vecs[7]  = '{3'd0, 16'hFFFF, 16'h0000, 16'h0000, 1'b1};
    vecs[8]  = '{3'd7, 16'h0001, 16'h1111, 16'hFFFF, 1'b0};
    vecs[9]  = '{3'd7, 16'h8000, 16'h0000, 16'h8000, 1'b0};
    vecs[10] = '{3'd7, 16'h0000, 16'hFFFF, 16'h0000, 1'b1};
    vecs[11] = '{3'd7, 16'hFFFF, 16'h0000, 16'h0001, 1'b0};

    m_count   = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_op     = 3'd0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_op_count", 32'(op_count), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_zero", 32'(out_zero), 32'd0);
    rst_n = 1'b1;

    // Table-driven op checks, one transaction each then drained
    for (int i = 0; i < 12; i++) begin
      cycle(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, 1'b1);
      chk("vec_valid", 32'(out_valid), 32'd1);
      chk("vec_data", 32'(out_data), 32'(vecs[i].exp_d));
      chk("vec_zero", 32'(out_zero), 32'(vecs[i].exp_z));
      cycle(1'b0, 3'd0, 16'h0, 16'h0, 1'b1);
    end

    // Back-pressure: three pushes with consumer stalled, only two accepted
    begin
      int c0;
      c0 = int'(op_count);
      cycle(1'b1, 3'd2, 16'h00FF, 16'h0F0F, 1'b0);
      cycle(1'b1, 3'd3, 16'h1000, 16'h0001, 1'b0);
      cycle(1'b1, 3'd5, 16'h1234, 16'h4321, 1'b0);
      chk("bp_in_ready_full", 32'(in_ready), 32'd0);
      chk("bp_two_accepted", 32'(op_count), 32'((c0 + 2) % 256));
      chk("bp_head_first", 32'(out_data), 32'h000F);
      // Pop with third op still held: refused this edge, accepted next
      cycle(1'b1, 3'd5, 16'h1234, 16'h4321, 1'b1);
      chk("bp_refused_on_pop", 32'(op_count), 32'((c0 + 2) % 256));
      chk("bp_second_head", 32'(out_data), 32'h1001);
      chk("bp_in_ready_after_pop", 32'(in_ready), 32'd1);
      cycle(1'b1, 3'd5, 16'h1234, 16'h4321, 1'b0);
      chk("bp_third_accepted", 32'(op_count), 32'((c0 + 3) % 256));
      repeat (3) cycle(1'b0, 3'd0, 16'h0, 16'h0, 1'b1);
      chk("bp_drained", 32'(out_valid), 32'd0);
    end

    // Reset mid-stream with two entries queued
    cycle(1'b1, 3'd0, 16'h0F0F, 16'h0, 1'b0);
    cycle(1'b1, 3'd0, 16'h00F0, 16'h0, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_op_count", 32'(op_count), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_out_data", 32'(out_data), 32'd0);
    q.delete();
    m_count = 0;
    #2;
    rst_n = 1'b1;
    cycle(1'b1, 3'd7, 16'h0003, 16'h0, 1'b0);
    chk("post_rst_accept", 32'(op_count), 32'd1);
    chk("post_rst_valid", 32'(out_valid), 32'd1);
    chk("post_rst_data", 32'(out_data), 32'hFFFD);
    cycle(1'b0, 3'd0, 16'h0, 16'h0, 1'b1);

    // NOT sweep across the operand space; op_count wraps repeatedly
    for (int i = 0; i < 4096; i++) begin
      cycle(1'b1, 3'd0, 16'((i * 16) | (i & 15)), 16'(i), 1'b1);
    end
    cycle(1'b1, 3'd0, 16'hFFFF, 16'h0, 1'b1);
    cycle(1'b0, 3'd0, 16'h0, 16'h0, 1'b1);
    cycle(1'b0, 3'd0, 16'h0, 16'h0, 1'b1);

    // Random streaming against the model
    for (int i = 0; i < 10000; i++) begin
      cycle(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
            16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 3'd0, 16'h0, 16'h0, 1'b1);
    end
    chk("final_empty", 32'(out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
